uop_seq_engine: RTL and testbench

Microcode sequencer that fetches and executes point-operation microprograms held in the 64-entry, 20-bit synchronous uop ROMs (doubling, addition). It drives the ROM address, decodes each word, handshakes it to the modular-arithmetic worker and evaluates the conditional-execution field. It stops on the RDY opcode. It sits between the curve-level controller, which pulses `ena`, and the ROM plus worker pair.

---
 rtl/uop_seq_engine_pkg.sv | 42 ++++
 rtl/uop_seq_decode.sv | 43 ++++
 rtl/uop_seq_engine.sv | 182 ++++++++++++++++++
 tb/tb_uop_seq_engine.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uop_seq_engine_pkg.sv
// Shared uop definitions: one-hot opcodes, exec codes, field layout and FSM state encodings.
package uop_seq_engine_pkg;

   localparam int unsigned UOP_LEN    = 20;
   localparam int unsigned OPC_W      = 6;
   localparam int unsigned UOP_SRC_W  = 4;
   localparam int unsigned UOP_DST_W  = 4;
   localparam int unsigned UOP_EXEC_W = 2;

   localparam int unsigned UOP_OPC_LSB  = 14;
   localparam int unsigned UOP_SRC1_LSB = 10;
   localparam int unsigned UOP_SRC2_LSB = 6;
   localparam int unsigned UOP_DST_LSB  = 2;
   localparam int unsigned UOP_EXEC_LSB = 0;

   localparam logic [OPC_W-1:0] OPCODE_CMP = 6'b100000;
   localparam logic [OPC_W-1:0] OPCODE_MOV = 6'b010000;
   localparam logic [OPC_W-1:0] OPCODE_ADD = 6'b001000;
   localparam logic [OPC_W-1:0] OPCODE_SUB = 6'b000100;
   localparam logic [OPC_W-1:0] OPCODE_MUL = 6'b000010;
   localparam logic [OPC_W-1:0] OPCODE_RDY = 6'b000001;

   localparam logic [UOP_EXEC_W-1:0] UOP_EXEC_ALWAYS     = 2'b00;
   localparam logic [UOP_EXEC_W-1:0] UOP_EXEC_PZT1T2_0XX = 2'b01;

   localparam int unsigned ST_W = 3;
   typedef logic [ST_W-1:0] state_t;
   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_FETCH = 3'd1;
   localparam state_t ST_LATCH = 3'd2;
   localparam state_t ST_EXEC  = 3'd3;
   localparam state_t ST_WAIT  = 3'd4;

   // Payload handed to the modular-arithmetic worker.
   typedef struct packed {
      logic [OPC_W-1:0]     opcode;
      logic [UOP_SRC_W-1:0] src1;
      logic [UOP_SRC_W-1:0] src2;
      logic [UOP_DST_W-1:0] dst;
   } op_req_t;

endpackage

// File: rtl/uop_seq_decode.sv
// Combinational uop decode: field slicing, terminate detection, exec-condition evaluation.
module uop_seq_decode
   import uop_seq_engine_pkg::*;
(
   input  logic [UOP_LEN-1:0]   uop,
   input  logic                 flag_pz0,
   output logic [OPC_W-1:0]     opcode,
   output logic [UOP_SRC_W-1:0] src1,
   output logic [UOP_SRC_W-1:0] src2,
   output logic [UOP_DST_W-1:0] dst,
   output logic                 term,
   output logic                 exec_ok
);

   logic [UOP_EXEC_W-1:0] exec;

   assign opcode = uop[UOP_OPC_LSB  +: OPC_W];
   assign src1   = uop[UOP_SRC1_LSB +: UOP_SRC_W];
   assign src2   = uop[UOP_SRC2_LSB +: UOP_SRC_W];
   assign dst    = uop[UOP_DST_LSB  +: UOP_DST_W];
   assign exec   = uop[UOP_EXEC_LSB +: UOP_EXEC_W];

   // Anything other than a single recognised worker opcode ends the program.
   always_comb begin
      term = 1'b1;
      case (opcode)
         OPCODE_CMP, OPCODE_MOV, OPCODE_ADD, OPCODE_SUB, OPCODE_MUL: term = 1'b0;
         OPCODE_RDY: term = 1'b1;
         default:    term = 1'b1;
      endcase
   end

   // Reserved exec codes behave as ALWAYS.
   always_comb begin
      exec_ok = 1'b1;
      case (exec)
         UOP_EXEC_ALWAYS:     exec_ok = 1'b1;
         UOP_EXEC_PZT1T2_0XX: exec_ok = flag_pz0;
         default:             exec_ok = 1'b1;
      endcase
   end

endmodule

// File: rtl/uop_seq_engine.sv
// Microcode sequencer for point-operation uop ROMs.
// Optional worker watchdog enabled by defining UOP_SEQ_WATCHDOG_EN.
module uop_seq_engine
   import uop_seq_engine_pkg::*;
#(
   parameter int unsigned ADDR_W     = 6,
   parameter int unsigned UOP_W      = 20,
   parameter int unsigned WDT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   output logic              rdy,
   output logic [ADDR_W-1:0] uop_addr,
   input  logic [UOP_W-1:0]  uop_data,
   output logic              op_ena,
   output logic [5:0]        op_code,
   output logic [3:0]        op_src1,
   output logic [3:0]        op_src2,
   output logic [3:0]        op_dst,
   input  logic              op_rdy,
   input  logic              op_cmp_eq,
   output logic              wdt_err
);

   if (UOP_W != UOP_LEN) begin : g_bad_uop_w
      $error("uop_seq_engine: UOP_W must match the packaged uop layout");
   end
   if (WDT_CYCLES < 2) begin : g_bad_wdt
      $error("uop_seq_engine: WDT_CYCLES must be at least 2");
   end

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              flag_q, flag_d;
   logic              term_q, exec_ok_q;
   op_req_t           op_q, op_d, dec_req;
   logic              rdy_d, op_ena_d;
   logic [ADDR_W-1:0] uop_addr_d;
   logic              pc_last_c, wdt_timeout_c, wdt_fire_c;

   logic [OPC_W-1:0]     dec_opc;
   logic [UOP_SRC_W-1:0] dec_src1, dec_src2;
   logic [UOP_DST_W-1:0] dec_dst;
   logic                 dec_term, dec_exec_ok;

   uop_seq_decode u_decode (
      .uop      (uop_data),
      .flag_pz0 (flag_q),
      .opcode   (dec_opc),
      .src1     (dec_src1),
      .src2     (dec_src2),
      .dst      (dec_dst),
      .term     (dec_term),
      .exec_ok  (dec_exec_ok)
   );

   assign dec_req    = {dec_opc, dec_src1, dec_src2, dec_dst};
   assign pc_last_c  = (pc_q == {ADDR_W{1'b1}});
   assign wdt_fire_c = (state_q == ST_WAIT) && !op_rdy && wdt_timeout_c;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next state, PC and PZ flag; the PC never wraps, address 63 ends the program.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      flag_d  = flag_q;
      case (state_q)
         ST_IDLE: begin
            if (ena) begin
               state_d = ST_FETCH;
               pc_d    = '0;
               flag_d  = 1'b0;
            end
         end
         ST_FETCH: state_d = ST_LATCH;
         ST_LATCH: state_d = ST_EXEC;
         ST_EXEC: begin
            if (term_q) begin
               state_d = ST_IDLE;
               pc_d    = '0;
            end else if (!exec_ok_q) begin
               if (pc_last_c) begin
                  state_d = ST_IDLE;
                  pc_d    = '0;
               end else begin
                  state_d = ST_FETCH;
                  pc_d    = pc_q + ADDR_W'(1);
               end
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (op_rdy) begin
               if (op_q.opcode == OPCODE_CMP) flag_d = op_cmp_eq;
               if (pc_last_c) begin
                  state_d = ST_IDLE;
                  pc_d    = '0;
               end else begin
                  state_d = ST_FETCH;
                  pc_d    = pc_q + ADDR_W'(1);
               end
            end else if (wdt_fire_c) begin
               state_d = ST_IDLE;
               pc_d    = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            pc_d    = '0;
         end
      endcase
   end

   // Output next values; the issue decision is taken in LATCH so op_ena is a flop during EXEC.
   always_comb begin
      rdy_d      = (state_d == ST_IDLE);
      uop_addr_d = (state_d == ST_IDLE) ? '0 : pc_d;
      op_ena_d   = (state_q == ST_LATCH) && !dec_term && dec_exec_ok;
      op_d       = op_ena_d ? dec_req : op_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q      <= '0;
         flag_q    <= 1'b0;
         term_q    <= 1'b0;
         exec_ok_q <= 1'b0;
         rdy       <= 1'b1;
         uop_addr  <= '0;
         op_ena    <= 1'b0;
         op_q      <= '0;
      end else begin
         pc_q     <= pc_d;
         flag_q   <= flag_d;
         rdy      <= rdy_d;
         uop_addr <= uop_addr_d;
         op_ena   <= op_ena_d;
         op_q     <= op_d;
         if (state_q == ST_LATCH) begin
            term_q    <= dec_term;
            exec_ok_q <= dec_exec_ok;
         end
      end
   end

   assign op_code = op_q.opcode;
   assign op_src1 = op_q.src1;
   assign op_src2 = op_q.src2;
   assign op_dst  = op_q.dst;

`ifdef UOP_SEQ_WATCHDOG_EN
   localparam int unsigned WDT_W = $clog2(WDT_CYCLES);
   logic [WDT_W-1:0] wdt_cnt_q;

   // Cycles elapsed since op_ena; fires so that IDLE is reached WDT_CYCLES after the issue.
   always_ff @(posedge clk) begin
      if (rst)                      wdt_cnt_q <= '0;
      else if (state_q == ST_EXEC)  wdt_cnt_q <= WDT_W'(1);
      else if (state_q == ST_WAIT)  wdt_cnt_q <= wdt_cnt_q + WDT_W'(1);
      else                          wdt_cnt_q <= '0;
   end

   assign wdt_timeout_c = (wdt_cnt_q == WDT_W'(WDT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst)                           wdt_err <= 1'b0;
      else if (state_q == ST_IDLE && ena) wdt_err <= 1'b0;
      else if (wdt_fire_c)               wdt_err <= 1'b1;
   end
`else
   assign wdt_timeout_c = 1'b0;
   assign wdt_err       = 1'b0;
`endif

endmodule

// File: tb/tb_uop_seq_engine.sv
// Self-checking bench for uop_seq_engine: stub ROM, scripted worker, program-walk reference model.
module tb_uop_seq_engine;

   localparam int unsigned ADDR_W = 6;
   localparam int unsigned UOP_W  = 20;
`ifdef UOP_SEQ_WATCHDOG_EN
   localparam int unsigned WDT = 16;
`else
   localparam int unsigned WDT = 1024;
`endif

   localparam logic [5:0] CMP = 6'b100000, MOV = 6'b010000, ADD = 6'b001000,
                          SUB = 6'b000100, MUL = 6'b000010, RDY = 6'b000001;

   logic clk = 1'b0;
   logic rst, ena, rdy, op_ena, op_rdy, op_cmp_eq, wdt_err;
   logic [ADDR_W-1:0] uop_addr;
   logic [UOP_W-1:0]  uop_data;
   logic [5:0] op_code;
   logic [3:0] op_src1, op_src2, op_dst;

   always #5 clk = ~clk;

   uop_seq_engine #(.ADDR_W(ADDR_W), .UOP_W(UOP_W), .WDT_CYCLES(WDT)) dut (
      .clk(clk), .rst(rst), .ena(ena), .rdy(rdy), .uop_addr(uop_addr), .uop_data(uop_data),
      .op_ena(op_ena), .op_code(op_code), .op_src1(op_src1), .op_src2(op_src2), .op_dst(op_dst),
      .op_rdy(op_rdy), .op_cmp_eq(op_cmp_eq), .wdt_err(wdt_err)
   );

   logic [UOP_W-1:0] rom [64];
   always @(posedge clk) uop_data <= rom[uop_addr];

   // Worker: answers L+1 cycles after seeing op_ena, with the next scripted CMP result.
   int wk_lat = 0, wk_cnt = 0, wk_idx = 0;
   bit wk_respond = 1'b1, wk_noise = 1'b0, wk_eq_cur = 1'b0;
   bit eq_bits [64];

   always @(negedge clk) begin
      op_rdy    = 1'b0;
      op_cmp_eq = 1'($urandom);
      if (wk_cnt > 0) begin
         wk_cnt--;
         if (wk_cnt == 0 && wk_respond) begin
            op_rdy    = 1'b1;
            op_cmp_eq = wk_eq_cur;
         end
      end else if (wk_noise && !op_ena && ($urandom % 5 == 0)) begin
         op_rdy = 1'b1;
      end
      if (op_ena) begin
         wk_cnt    = wk_lat + 1;
         wk_eq_cur = eq_bits[wk_idx % 64];
         wk_idx++;
      end
   end

   int n_cmp = 0, n_bad = 0;

   logic [17:0] exp_q[$], got_q[$];
   int exp_done, exp_last, got_done, got_max, ena_viol;
   bit zero_mid, rdy_c1;

   function automatic logic [UOP_W-1:0] mk(input logic [5:0] opc, input logic [1:0] ex);
      return {opc, 4'($urandom), 4'($urandom), 4'($urandom), ex};
   endfunction

   // Walks the program as the sequencer should: cycle totals, issued payloads, last address.
   task automatic model(input int lat);
      int pc, n;
      bit flag, done;
      logic [UOP_W-1:0] w;
      logic [5:0] opc;
      exp_q.delete();
      pc = 0; n = 0; flag = 1'b0; done = 1'b0; exp_done = 1;
      while (!done) begin
         w = rom[pc]; exp_last = pc; opc = w[19:14];
         if (!(opc inside {CMP, MOV, ADD, SUB, MUL})) begin
            exp_done += 3;
            done = 1'b1;
         end else begin
            if (w[1:0] == 2'b01 && !flag) begin
               exp_done += 3;
            end else begin
               exp_q.push_back(w[19:2]);
               exp_done += 4 + lat;
               if (opc == CMP) flag = eq_bits[n];
               n++;
            end
            if (pc == 63) done = 1'b1;
            else pc++;
         end
      end
   endtask

   task automatic run_prog(input int lat, input bit ena_noise, input string tag);
      int cyc;
      bit prev_ena, seen_nz;
      wk_lat = lat; wk_idx = 0; wk_cnt = 0; wk_respond = 1'b1;
      model(lat);
      got_q.delete();
      got_max = 0; zero_mid = 1'b0; ena_viol = 0; prev_ena = 1'b0; seen_nz = 1'b0;
      got_done = -1; rdy_c1 = 1'b1;
      @(negedge clk); ena = 1'b1; cyc = 0;
      while (cyc < 4000) begin
         @(negedge clk); cyc++;
         if (cyc == 1) rdy_c1 = rdy;
         if (op_ena) begin
            got_q.push_back({op_code, op_src1, op_src2, op_dst});
            if (prev_ena) ena_viol++;
         end
         prev_ena = op_ena;
         if (int'(uop_addr) > got_max) got_max = int'(uop_addr);
         if (uop_addr != 0) seen_nz = 1'b1;
         else if (seen_nz && !rdy) zero_mid = 1'b1;
         if (rdy) begin
            got_done = cyc;
            break;
         end
         ena = ena_noise ? ($urandom % 3 == 0) : 1'b0;
      end
      ena = 1'b0;
      n_cmp++; if (rdy_c1 !== 1'b0) begin n_bad++; $display("FAIL %s rdy_cycle1: got %0b expected 0", tag, rdy_c1); end
      n_cmp++; if (got_done !== exp_done) begin n_bad++; $display("FAIL %s done_cycle: got %0d expected %0d", tag, got_done, exp_done); end
      n_cmp++; if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL %s issue_count: got %0d expected %0d", tag, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_cmp++;
         if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL %s issue[%0d]: got %h expected %h", tag, i, got_q[i], exp_q[i]); end
      end
      n_cmp++; if (got_max !== exp_last) begin n_bad++; $display("FAIL %s last_addr: got %0d expected %0d", tag, got_max, exp_last); end
      n_cmp++; if (zero_mid !== 1'b0) begin n_bad++; $display("FAIL %s addr_zero_midrun: got %0b expected 0", tag, zero_mid); end
      n_cmp++; if (ena_viol !== 0) begin n_bad++; $display("FAIL %s op_ena_width: got %0d long pulses expected 0", tag, ena_viol); end
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 64; i++) rom[i] = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1; ena = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (rdy !== 1'b1)      begin n_bad++; $display("FAIL reset_rdy: got %b expected 1", rdy); end
      n_cmp++; if (op_ena !== 1'b0)   begin n_bad++; $display("FAIL reset_op_ena: got %b expected 0", op_ena); end
      n_cmp++; if (uop_addr !== '0)   begin n_bad++; $display("FAIL reset_uop_addr: got %0d expected 0", uop_addr); end
      n_cmp++; if (op_code !== 6'd0)  begin n_bad++; $display("FAIL reset_op_code: got %b expected 0", op_code); end
      n_cmp++; if ({op_src1, op_src2, op_dst} !== 12'd0) begin n_bad++; $display("FAIL reset_operands: got %h expected 0", {op_src1, op_src2, op_dst}); end
      n_cmp++; if (wdt_err !== 1'b0)  begin n_bad++; $display("FAIL reset_wdt_err: got %b expected 0", wdt_err); end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      clear_rom();
      rom[0] = mk(MOV, 2'b00);
      rom[1] = mk(ADD, 2'(2 + $urandom_range(0, 1)));
      rom[2] = mk(RDY, 2'b00);
      run_prog(3, 1'b0, "basic");
      n_cmp++; if (got_done !== 18) begin n_bad++; $display("FAIL basic_latency: got %0d expected 18", got_done); end
   endtask

   task automatic test_cond();
      for (int eq = 0; eq < 2; eq++) begin
         clear_rom();
         rom[0] = mk(CMP, 2'b00);
         rom[1] = mk(MOV, 2'b01);
         rom[2] = mk(RDY, 2'b00);
         eq_bits[0] = eq[0];
         run_prog($urandom_range(0, 3), 1'b0, eq ? "cond_eq1" : "cond_eq0");
         n_cmp++;
         if (got_q.size() !== (eq ? 2 : 1)) begin n_bad++; $display("FAIL cond_issue_count eq=%0d: got %0d expected %0d", eq, got_q.size(), eq ? 2 : 1); end
      end
   endtask

   task automatic test_zero_word();
      clear_rom();
      rom[0] = mk(ADD, 2'b00);
      rom[1] = mk(SUB, 2'b00);
      rom[2] = '0;
      rom[3] = mk(MUL, 2'b00);
      run_prog(1, 1'b0, "zero_word");
      n_cmp++; if (got_max !== 2) begin n_bad++; $display("FAIL zero_word_max_addr: got %0d expected 2", got_max); end
   endtask

   task automatic test_wrap();
      logic [5:0] ops [5];
      ops[0] = CMP; ops[1] = MOV; ops[2] = ADD; ops[3] = SUB; ops[4] = MUL;
      for (int i = 0; i < 64; i++) rom[i] = mk(ops[$urandom_range(1, 4)], 2'b00);
      run_prog(0, 1'b0, "wrap");
      n_cmp++; if (got_max !== 63) begin n_bad++; $display("FAIL wrap_max_addr: got %0d expected 63", got_max); end
      n_cmp++; if (got_q.size() !== 64) begin n_bad++; $display("FAIL wrap_issue_count: got %0d expected 64", got_q.size()); end
   endtask

   task automatic test_random_back_to_back();
      logic [5:0] ops [5];
      int sel;
      ops[0] = CMP; ops[1] = MOV; ops[2] = ADD; ops[3] = SUB; ops[4] = MUL;
      wk_noise = 1'b1;
      for (int it = 0; it < 20; it++) begin
         for (int i = 0; i < 64; i++) begin
            sel = $urandom % 20;
            if (sel < 16)       rom[i] = mk(ops[sel % 5], 2'($urandom));
            else if (sel == 16) rom[i] = mk(RDY, 2'($urandom));
            else if (sel == 17) rom[i] = '0;
            else if (sel == 18) rom[i] = mk(6'($urandom), 2'($urandom));
            else                rom[i] = 20'($urandom % 4096);
            eq_bits[i] = 1'($urandom);
         end
         run_prog($urandom_range(0, 4), 1'b1, "random");
      end
      wk_noise = 1'b0;
   endtask

   task automatic test_reset_in_wait();
      int cyc, viol;
      bit seen;
      clear_rom();
      rom[0] = mk(MOV, 2'b00);
      rom[1] = mk(RDY, 2'b00);
      wk_lat = 10; wk_cnt = 0; wk_respond = 1'b1;
      @(negedge clk); ena = 1'b1;
      @(negedge clk); ena = 1'b0;
      seen = op_ena;
      for (cyc = 0; cyc < 20 && !seen; cyc++) begin
         @(negedge clk);
         seen = op_ena;
      end
      n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL rst_wait_issue: got %0b expected 1", seen); end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++; if ({rdy, op_ena} !== 2'b10) begin n_bad++; $display("FAIL rst_wait_state: got rdy,op_ena=%b expected 10", {rdy, op_ena}); end
      n_cmp++; if (uop_addr !== '0) begin n_bad++; $display("FAIL rst_wait_addr: got %0d expected 0", uop_addr); end
      viol = 0;
      repeat (15) begin
         @(negedge clk);
         if (rdy !== 1'b1 || op_ena !== 1'b0 || uop_addr !== '0) viol++;
      end
      n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL rst_wait_late_op_rdy: got %0d disturbed cycles expected 0", viol); end
   endtask

`ifdef UOP_SEQ_WATCHDOG_EN
   task automatic test_watchdog();
      bit seen;
      int cyc;
      clear_rom();
      rom[0] = mk(MOV, 2'b00);
      rom[1] = mk(RDY, 2'b00);
      wk_respond = 1'b0; wk_cnt = 0;
      @(negedge clk); ena = 1'b1;
      @(negedge clk); ena = 1'b0;
      seen = op_ena;
      for (cyc = 0; cyc < 20 && !seen; cyc++) begin
         @(negedge clk);
         seen = op_ena;
      end
      n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL wdt_issue: got %0b expected 1", seen); end
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (k == 15) begin
            n_cmp++; if ({rdy, wdt_err} !== 2'b00) begin n_bad++; $display("FAIL wdt_early: got rdy,wdt_err=%b expected 00", {rdy, wdt_err}); end
         end
      end
      n_cmp++; if ({rdy, wdt_err} !== 2'b11) begin n_bad++; $display("FAIL wdt_fire: got rdy,wdt_err=%b expected 11", {rdy, wdt_err}); end
      wk_respond = 1'b1; wk_lat = 1; wk_cnt = 0;
      @(negedge clk); ena = 1'b1;
      @(negedge clk); ena = 1'b0;
      n_cmp++; if ({rdy, wdt_err} !== 2'b00) begin n_bad++; $display("FAIL wdt_clear: got rdy,wdt_err=%b expected 00", {rdy, wdt_err}); end
      for (cyc = 0; cyc < 50 && !rdy; cyc++) @(negedge clk);
      n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL wdt_recover: got rdy=%b expected 1", rdy); end
   endtask
`endif

   initial begin
      rst = 1'b1; ena = 1'b0;
      clear_rom();
      for (int i = 0; i < 64; i++) eq_bits[i] = 1'b0;
      test_reset();
      test_basic();
      test_cond();
      test_zero_word();
      test_wrap();
      test_random_back_to_back();
      test_reset_in_wait();
      test_basic();
`ifdef UOP_SEQ_WATCHDOG_EN
      test_watchdog();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
